// File: rtl/uop_buffer_pkg.sv
// Shared uop definitions used by the buffer, uop fetch and the microcode unit.
// Default depth and the bundle layout live here so all consumers agree.
package uop_buffer_pkg;

    localparam int UOP_BUF_SIZE = 16;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [15:0] imm;
    } instruction_bundle;

endpackage

// File: rtl/uop_buf_ptr.sv
// Wrapping slot pointer with increment and synchronous clear (clear wins).
// Latency: one cycle; no backpressure, callers gate inc.
module uop_buf_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    // Power-of-two depth, so natural overflow is the wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uop_buffer.sv
// Circular uop bundle buffer feeding fetch; zero-latency random read, in-order pop.
// Backpressure: wr_ready from registered state only. Optional stats: UOP_BUF_STATS_EN.
module uop_buffer
    import uop_buffer_pkg::instruction_bundle;
#(
    parameter int UOP_BUF_SIZE = uop_buffer_pkg::UOP_BUF_SIZE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  instruction_bundle               wr_bundle,
    input  logic [$clog2(UOP_BUF_SIZE)-1:0] uop_addr,
    output instruction_bundle               uop,
    output logic                            uop_hit,
    output logic [$clog2(UOP_BUF_SIZE)-1:0] head_addr,
    output logic [$clog2(UOP_BUF_SIZE):0]   count,
    input  logic                            rd_pop,
    output logic                            underflow
`ifdef UOP_BUF_STATS_EN
    ,
    output logic [$clog2(UOP_BUF_SIZE):0]   stat_hwm,
    output logic [31:0]                     stat_full_cyc
`endif
);

    localparam int PW    = $clog2(UOP_BUF_SIZE);
    localparam int CNT_W = PW + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(UOP_BUF_SIZE);

    logic              ready_q;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     rel;
    logic              push;
    logic              pop;
    logic              push_eff;
    logic              pop_eff;
    instruction_bundle mem [UOP_BUF_SIZE];

    assign wr_ready = ready_q && (count != FULL);
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_pop && (count != '0);
    assign push_eff = push && !flush;
    assign pop_eff  = pop && !flush;

    uop_buf_ptr #(.W(PW)) u_head (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_eff),
        .clr   (flush),
        .ptr   (head_addr)
    );

    uop_buf_ptr #(.W(PW)) u_tail (
        .clk   (clk),
        .reset (reset),
        .inc   (push_eff),
        .clr   (flush),
        .ptr   (tail)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q   <= 1'b0;
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (rd_pop && (count == '0)) begin
                underflow <= 1'b1;
            end
            if (flush) begin
                count <= '0;
            end else begin
                case ({push_eff, pop_eff})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is deliberately not reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[tail] <= wr_bundle;
        end
    end

    assign uop     = mem[uop_addr];
    assign rel     = uop_addr - head_addr;
    assign uop_hit = {1'b0, rel} < count;

`ifdef UOP_BUF_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hwm      <= '0;
            stat_full_cyc <= '0;
        end else begin
            if (count > stat_hwm) begin
                stat_hwm <= count;
            end
            if ((count == FULL) && (stat_full_cyc != 32'hFFFF_FFFF)) begin
                stat_full_cyc <= stat_full_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uop_buffer.sv
// Randomized bench for uop_buffer (depth 4) against a queue-based reference model.
module tb_uop_buffer;
    import uop_buffer_pkg::*;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              wr_valid = 1'b0;
    logic              rd_pop = 1'b0;
    instruction_bundle wr_bundle = '0;
    logic [1:0]        uop_addr = '0;
    logic              wr_ready;
    instruction_bundle uop;
    logic              uop_hit;
    logic [1:0]        head_addr;
    logic [2:0]        count;
    logic              underflow;
`ifdef UOP_BUF_STATS_EN
    logic [2:0]        stat_hwm;
    logic [31:0]       stat_full_cyc;
`endif

    uop_buffer #(.UOP_BUF_SIZE(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_bundle (wr_bundle),
        .uop_addr  (uop_addr),
        .uop       (uop),
        .uop_hit   (uop_hit),
        .head_addr (head_addr),
        .count     (count),
        .rd_pop    (rd_pop),
        .underflow (underflow)
`ifdef UOP_BUF_STATS_EN
        ,
        .stat_hwm      (stat_hwm),
        .stat_full_cyc (stat_full_cyc)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of live bundles plus the slot contents last written.
    instruction_bundle q[$];
    int                mhead = 0;
    instruction_bundle mmem [N];
    bit                mwr  [N];
    bit                mready = 0;
    bit                munder = 0;
    int                mhwm = 0;
    longint            mfull = 0;

    function automatic bit exp_hit(input int a);
        for (int i = 0; i < q.size(); i++)
            if ((mhead + i) % N == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        mhead = 0;
        mready = 0;
        munder = 0;
        mhwm = 0;
        mfull = 0;
    endtask

    task automatic check_outputs();
        int a;
        a = int'(uop_addr);
        chk("wr_ready", wr_ready, mready && (q.size() < N));
        chk("count", count, q.size());
        chk("head_addr", head_addr, mhead);
        chk("underflow", underflow, munder);
        chk("uop_hit", uop_hit, exp_hit(a));
        if (mwr[a]) chk("uop", uop, mmem[a]);
        if (exp_hit(a)) chk("uop_live", uop, q[(a - mhead + N) % N]);
`ifdef UOP_BUF_STATS_EN
        chk("stat_hwm", stat_hwm, mhwm);
        chk("stat_full_cyc", stat_full_cyc, mfull);
`endif
    endtask

    task automatic tick();
        bit push, pop, uf, fl;
        int pre, t;
        instruction_bundle b;
        #1;
        check_outputs();
        pre  = q.size();
        push = wr_valid && mready && (pre < N);
        pop  = rd_pop && (pre != 0);
        uf   = rd_pop && (pre == 0);
        fl   = flush;
        b    = wr_bundle;
        @(posedge clk);
        if (uf) munder = 1;
        if (pre == N && mfull < 64'hFFFF_FFFF) mfull++;
        if (pre > mhwm) mhwm = pre;
        if (fl) begin
            q.delete();
            mhead = 0;
        end else begin
            if (push) begin
                t = (mhead + pre) % N;
                mmem[t] = b;
                mwr[t] = 1;
                q.push_back(b);
            end
            if (pop) begin
                void'(q.pop_front());
                mhead = (mhead + 1) % N;
            end
        end
        mready = 1;
        #1;
    endtask

    task automatic set_in(input bit v, input bit p, input bit f, input logic [31:0] d);
        wr_valid  = v;
        rd_pop    = p;
        flush     = f;
        wr_bundle = instruction_bundle'(d);
    endtask

    initial begin
        for (int i = 0; i < N; i++) mwr[i] = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_head", head_addr, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_underflow", underflow, 0);
        for (int a = 0; a < N; a++) begin
            uop_addr = 2'(a);
            #1;
            chk("rst_hit", uop_hit, 0);
        end
        reset = 1'b1;
        #1;
        chk("rel_wr_ready0", wr_ready, 0);
        tick();
        chk("rel_wr_ready1", wr_ready, 1);

        // Fill A..D, then E stalls
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 32'hA000_0000 + i);
            tick();
        end
        uop_addr = 2'd2;
        set_in(1, 0, 0, 32'hE000_0004);
        #1;
        chk("full_count", count, 4);
        chk("full_wr_ready", wr_ready, 0);
        chk("full_uop_c", uop, 32'hA000_0002);
        chk("full_hit2", uop_hit, 1);
        tick();
        chk("stall_count", count, 4);

        // Full + pop + push: pop only this cycle, E lands next
        uop_addr = 2'd0;
        set_in(1, 1, 0, 32'hE000_0004);
        tick();
        chk("fp_count", count, 3);
        chk("fp_head", head_addr, 1);
        chk("fp_uop0_old", uop, 32'hA000_0000);
        set_in(1, 0, 0, 32'hE000_0004);
        tick();
        chk("fp_count_n1", count, 4);
        chk("fp_uop0_e", uop, 32'hE000_0004);
        chk("fp_hit0", uop_hit, 1);

        // Wrap: 6 pushes and 5 pops total
        set_in(0, 1, 0, 0);
        repeat (4) tick();
        set_in(1, 0, 0, 32'hF000_0005);
        tick();
        set_in(0, 0, 0, 0);
        uop_addr = 2'd1;
        #1;
        chk("wrap_head", head_addr, 1);
        chk("wrap_count", count, 1);
        chk("wrap_hit1", uop_hit, 1);
        uop_addr = 2'd0;
        #1;
        chk("wrap_hit0", uop_hit, 0);

        // Underflow
        set_in(0, 1, 0, 0);
        tick();
        tick();
        chk("uf_count", count, 0);
        chk("uf_flag", underflow, 1);

        // Flush with push and pop at count 2
        set_in(1, 0, 0, 32'h1111_0001);
        tick();
        set_in(1, 0, 0, 32'h1111_0002);
        tick();
        set_in(1, 1, 1, 32'h1111_0003);
        tick();
        chk("fl_count", count, 0);
        chk("fl_head", head_addr, 0);
        chk("fl_underflow", underflow, 1);
        set_in(1, 0, 0, 32'h6666_0006);
        tick();
        uop_addr = 2'd0;
        #1;
        chk("fl_tail0", uop, 32'h6666_0006);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 31) == 0, $urandom);
            uop_addr = 2'($urandom_range(0, 3));
            tick();
        end

        // Reset mid-stream
        set_in(1, 0, 0, 32'h7777_0007);
        tick();
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_wr_ready", wr_ready, 0);
        chk("mid_rst_underflow", underflow, 0);
        set_in(0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Fill, hold full, flush
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 32'hC000_0000 + i);
            tick();
        end
        set_in(0, 0, 0, 0);
        repeat (9) tick();
        set_in(0, 0, 1, 0);
        tick();
        set_in(0, 0, 0, 0);
        tick();
        chk("post_fl_count", count, 0);
`ifdef UOP_BUF_STATS_EN
        chk("stat_hwm_4", stat_hwm, 4);
        chk("stat_full_10", stat_full_cyc, 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
